fdc_spi_host: RTL and testbench
===============================

# fdc_spi_host

SPI master that drives the floppy-controller SRAM bridge's byte protocol from the host side. It accepts single ADDR / WRITE / READ commands on a valid/ready port and serializes each one as an SPI mode-0 transaction framed by `ss`. It returns read bytes and mirrors the bridge's auto-incrementing address pointer. It sits in the host-side FPGA/CPLD between the disk-image engine and the `sclk/mosi/miso/ss` wires of the CoCo cartridge.

## Interface
Parameters:
- `CLK_DIV`, 6: `clock_50` cycles per SCK half-period (4.17 MHz SCK).
- `SS_SETUP`, 4: cycles `ss` is low before the first SCK edge; also the `ss`-low hold after the last edge and the minimum `ss`-high time.
- `GAP_CYCLES`, 32: idle cycles between bytes within one transaction. This covers the bridge's SRAM access.

Ports:
- `clock_50`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller idle; accept on `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  01 ADDR, 10 WRITE, 11 READ, 00 NOP.
- `cmd_addr`  in  16  address for ADDR.
- `cmd_wdata`  in  8  data for WRITE.
- `rsp_valid`  out  1  one-cycle pulse: READ data valid.
- `rsp_data`  out  8  last byte read; holds until the next READ.
- `cur_addr`  out  16  mirror of the bridge address pointer.
- `busy`  out  1  transaction in progress (equals `~cmd_ready`).
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  SPI data out, MSB first.
- `miso`  in  1  SPI data in.
- `ss`  out  1  slave select, active low.

## Operation
- On accept, latch `cmd_op`, `cmd_addr` and `cmd_wdata`. Inputs are ignored while `cmd_ready` = 0.
- Byte sequences per command:
  - ADDR: 0x01, addr[15:8], addr[7:0].
  - WRITE: 0x02, wdata.
  - READ: 0x03, then 0x00 dummy; the MISO byte captured during the dummy byte goes to `rsp_data`.
- NOP: accepted; produces no `ss` activity and no `rsp_valid`. `cmd_ready` returns 1 on the next cycle.
- States and transitions:
  - IDLE → SETUP on accept of a non-NOP command.
  - SETUP → SHIFT.
  - SHIFT → GAP if more bytes remain, otherwise SHIFT → HOLD.
  - GAP → SHIFT.
  - HOLD → RELEASE.
  - RELEASE → IDLE.
- Byte counter: 2 bits. Bit counter: 3 bits. Phase counter: counts to `CLK_DIV`-1.
- `cur_addr` updates:
  - ADDR sets it to `cmd_addr` at completion.
  - WRITE and READ increment it by 1 at completion, modulo 2^16 (0xFFFF → 0x0000).
  - NOP leaves it unchanged.
- `rsp_valid` and `rsp_data` update on the cycle entering RELEASE, for READ only.

## Timing
- Reset values (applied at the clock edge with `reset` = 1; also aborts any transaction mid-byte):
  - `ss` = 1, `sclk` = 0, `mosi` = 0.
  - `cmd_ready` = 1, `busy` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0x00, `cur_addr` = 0x0000.
- Reset mid-transaction: the bridge discards the partial byte when `ss` rises. No response is produced.
- Cycle 0 is the accept cycle. Cycle 1: `ss` = 0, `mosi` = bit 7 of byte 0, `sclk` = 0. SETUP lasts `SS_SETUP` cycles.
- Each bit: `CLK_DIV` cycles with `sclk` = 0, then `CLK_DIV` cycles with `sclk` = 1.
  - `mosi` changes only on the first cycle of the low phase.
  - `miso` is sampled on the clock edge where `sclk` goes 0→1.
  - One byte = 16·`CLK_DIV` = 96 cycles.
- GAP: `GAP_CYCLES` cycles with `sclk` = 0 and `ss` = 0. HOLD: `SS_SETUP` cycles with `ss` = 0.
- RELEASE: `ss` = 1 for `SS_SETUP` cycles, then IDLE with `cmd_ready` = 1.
- Defaults, for WRITE/READ:
  - Cycles 1–4: SETUP.
  - Cycles 5–100: byte 0.
  - Cycles 101–132: GAP.
  - Cycles 133–228: byte 1.
  - Cycles 229–232: HOLD.
  - Cycles 233–236: `ss` high; `rsp_valid` = 1 at cycle 233.
  - Cycle 237: `cmd_ready` = 1.
- ADDR completes at cycle 365. NOP completes at cycle 1.
- `cmd_valid` held high across completion: the next command is accepted on the first cycle `cmd_ready` = 1. No idle cycle is inserted beyond RELEASE.

## Test plan
- ADDR 0x1234 after reset → MOSI bytes 0x01, 0x12, 0x34 under a single `ss`-low window; `cur_addr` = 0x1234 at cycle 365; `cmd_ready` rises at cycle 365.
- WRITE 0xA5 with `cur_addr` = 0x1234 → MOSI bytes 0x02, 0xA5; bits change only while `sclk` = 0; `cur_addr` = 0x1235; `rsp_valid` never asserts.
- READ with the slave model driving 0x3C on the second byte → `rsp_valid` is a single pulse at cycle 233 with `rsp_data` = 0x3C; MOSI bytes are 0x03, 0x00; `rsp_data` holds 0x3C through a following WRITE.
- ADDR 0xFFFF then READ → `cur_addr` reads 0x0000 after the READ.
- `reset` asserted at cycle 50 of a WRITE → on the next edge `ss` = 1, `sclk` = 0, `cmd_ready` = 1, `cur_addr` = 0x0000; a following ADDR 0x0010 then runs normally.
- `cmd_valid` held high with NOP, then READ, with `cmd_op` changed on the accept cycle → NOP completes in 1 cycle with no `ss` activity; READ is accepted on the next cycle; changing `cmd_op` or `cmd_wdata` mid-transaction has no effect on MOSI.

Source files
------------

// File: rtl/fdc_spi_host.sv
// Host-side SPI master for the floppy-controller SRAM bridge.
// Serializes ADDR/WRITE/READ commands as mode-0 SPI transactions.
module fdc_spi_host #(
  parameter int CLK_DIV    = 6,
  parameter int SS_SETUP   = 4,
  parameter int GAP_CYCLES = 32
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] cur_addr,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, GAP, HOLD, RELEASE
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADDR = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  localparam int TMAX = (GAP_CYCLES > SS_SETUP) ? GAP_CYCLES : SS_SETUP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(CLK_DIV + 1);

  localparam logic [TW-1:0] T_SS  = TW'(SS_SETUP - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [PW-1:0] P_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  state_t        state, nxt;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] phase;
  logic          hi;
  logic [2:0]    bitcnt;
  logic [1:0]    bytecnt;
  logic [1:0]    op;
  logic [15:0]   addr_l;
  logic [7:0]    shreg;
  logic [15:0]   pend;
  logic [7:0]    rx;

  logic accept, ph_end, byte_end;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign ph_end    = (phase == P_END);
  assign byte_end  = hi & ph_end & (bitcnt == 3'd7);
  assign sclk      = (state == SHIFT) & hi;
  assign mosi      = shreg[7];
  assign ss        = (state == IDLE) | (state == RELEASE);

  always_ff @(posedge clock_50) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept && cmd_op != OP_NOP) nxt = SETUP;
      SETUP:   if (tcnt == T_SS) nxt = SHIFT;
      SHIFT:   if (byte_end) nxt = (bytecnt != 2'd0) ? GAP : HOLD;
      GAP:     if (tcnt == T_GAP) nxt = SHIFT;
      HOLD:    if (tcnt == T_SS) nxt = RELEASE;
      RELEASE: if (tcnt == T_SS) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      tcnt      <= '0;
      phase     <= '0;
      hi        <= 1'b0;
      bitcnt    <= 3'd0;
      bytecnt   <= 2'd0;
      op        <= OP_NOP;
      addr_l    <= 16'h0000;
      shreg     <= 8'h00;
      pend      <= 16'h0000;
      rx        <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      cur_addr  <= 16'h0000;
    end else begin
      rsp_valid <= 1'b0;
      tcnt      <= (nxt != state) ? '0 : tcnt + T_ONE;
      unique case (state)
        IDLE: begin
          if (nxt == SETUP) begin
            op     <= cmd_op;
            addr_l <= cmd_addr;
            phase  <= '0;
            hi     <= 1'b0;
            bitcnt <= 3'd0;
            unique case (1'b1)
              cmd_op == OP_ADDR: begin
                shreg   <= 8'h01;
                pend    <= cmd_addr;
                bytecnt <= 2'd2;
              end
              cmd_op == OP_WR: begin
                shreg   <= 8'h02;
                pend    <= {cmd_wdata, 8'h00};
                bytecnt <= 2'd1;
              end
              default: begin
                shreg   <= 8'h03;
                pend    <= 16'h0000;
                bytecnt <= 2'd1;
              end
            endcase
          end
        end
        SHIFT: begin
          if (ph_end) begin
            phase <= '0;
            hi    <= ~hi;
            // rising sclk samples miso; falling edge advances mosi
            if (!hi) begin
              rx <= {rx[6:0], miso};
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt + 3'd1;
            end
          end else begin
            phase <= phase + P_ONE;
          end
          if (byte_end) bytecnt <= bytecnt - 2'd1;
        end
        GAP: begin
          if (nxt == SHIFT) begin
            shreg <= pend[15:8];
            pend  <= {pend[7:0], 8'h00};
          end
        end
        HOLD: begin
          if (nxt == RELEASE && op == OP_RD) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx;
          end
        end
        RELEASE: begin
          if (nxt == IDLE) begin
            if (op == OP_ADDR) cur_addr <= addr_l;
            else               cur_addr <= cur_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc_spi_host.sv
// Directed bench for fdc_spi_host with a behavioral bridge-side slave.
// Checks framing, byte streams, cycle timing, address mirror and reset.
module tb_fdc_spi_host;

  logic        clock_50 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] cur_addr;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;

  int checks = 0;
  int errors = 0;

  fdc_spi_host dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .cur_addr (cur_addr),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .ss       (ss)
  );

  always #5 clock_50 = ~clock_50;

  // slave: captures mosi on sclk rise, returns rd_byte as the second byte
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] sh_in = 8'h00;
  logic [7:0] mbytes[$];
  int         sbit = 0;
  int         ss_falls = 0;

  always @(negedge ss or posedge sclk) begin
    if (sclk) begin
      sh_in = {sh_in[6:0], mosi};
      sbit++;
      if (sbit % 8 == 0) mbytes.push_back(sh_in);
    end else begin
      sbit = 0;
      ss_falls++;
    end
  end

  always_comb begin
    miso = 1'b1;
    if (sbit >= 8 && sbit < 16) miso = rd_byte[3'(15 - sbit)];
  end

  int   mosi_bad = 0;
  logic pm = 1'b0;
  always @(negedge clock_50) begin
    if (mosi !== pm && sclk === 1'b1) mosi_bad++;
    pm = mosi;
  end

  int mb0, sf0, mbad0;
  int rdy_cyc, rv_cyc, rv_n, ss_c1;

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [7:0] d);
    int n = 0;
    @(negedge clock_50);
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clock_50);
      n++;
    end
    mb0   = mbytes.size();
    sf0   = ss_falls;
    mbad0 = mosi_bad;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge clock_50);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    rdy_cyc = -1;
    rv_cyc  = -1;
    rv_n    = 0;
    ss_c1   = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clock_50);
      if (c == 1) ss_c1 = int'(ss);
      if (rsp_valid === 1'b1) begin
        rv_n++;
        if (rv_cyc < 0) rv_cyc = c;
      end
      if (cmd_ready === 1'b1) begin
        rdy_cyc = c;
        break;
      end
      cmd_op    = 2'($urandom);
      cmd_addr  = 16'($urandom);
      cmd_wdata = 8'($urandom);
    end
  endtask

  function automatic logic [7:0] mb(input int i);
    if (i < mbytes.size()) return mbytes[i];
    return 8'hxx;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock_50);
    #1 reset = 1'b0;
    @(negedge clock_50);
    checks++;
    if ({ss, sclk, mosi} !== 3'b100) begin
      errors++;
      $display("FAIL reset_pins: got %b want 100", {ss, sclk, mosi});
    end
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs: got %b want 100",
               {cmd_ready, busy, rsp_valid});
    end
    checks++;
    if (rsp_data !== 8'h00 || cur_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h want 00/0000",
               rsp_data, cur_addr);
    end
  endtask

  task automatic test_addr;
    issue(2'b01, 16'h1234, 8'h00);
    wait_done(600);
    checks++;
    if (rdy_cyc !== 365) begin
      errors++;
      $display("FAIL addr_ready_cyc: got %0d want 365", rdy_cyc);
    end
    checks++;
    if (cur_addr !== 16'h1234) begin
      errors++;
      $display("FAIL addr_cur: got %h want 1234", cur_addr);
    end
    checks++;
    if ({mb(mb0), mb(mb0+1), mb(mb0+2)} !== 24'h011234) begin
      errors++;
      $display("FAIL addr_bytes: got %h want 011234",
               {mb(mb0), mb(mb0+1), mb(mb0+2)});
    end
    checks++;
    if (ss_falls - sf0 !== 1 || ss_c1 !== 0) begin
      errors++;
      $display("FAIL addr_ss: falls %0d c1 %0d want 1 0",
               ss_falls - sf0, ss_c1);
    end
  endtask

  task automatic test_write;
    issue(2'b10, 16'hBEEF, 8'hA5);
    wait_done(600);
    checks++;
    if ({mb(mb0), mb(mb0+1)} !== 16'h02A5 || mbytes.size() !== mb0 + 2) begin
      errors++;
      $display("FAIL write_bytes: got %h want 02a5", {mb(mb0), mb(mb0+1)});
    end
    checks++;
    if (cur_addr !== 16'h1235) begin
      errors++;
      $display("FAIL write_cur: got %h want 1235", cur_addr);
    end
    checks++;
    if (rv_n !== 0 || rdy_cyc !== 237) begin
      errors++;
      $display("FAIL write_rv: rv %0d rdy %0d want 0 237", rv_n, rdy_cyc);
    end
    checks++;
    if (mosi_bad - mbad0 !== 0) begin
      errors++;
      $display("FAIL write_mosi_edge: got %0d want 0", mosi_bad - mbad0);
    end
  endtask

  task automatic test_read;
    rd_byte = 8'h3C;
    issue(2'b11, 16'h0000, 8'h00);
    wait_done(600);
    checks++;
    if (rv_cyc !== 233 || rv_n !== 1) begin
      errors++;
      $display("FAIL read_rv: cyc %0d n %0d want 233 1", rv_cyc, rv_n);
    end
    checks++;
    if (rsp_data !== 8'h3C) begin
      errors++;
      $display("FAIL read_data: got %h want 3c", rsp_data);
    end
    checks++;
    if ({mb(mb0), mb(mb0+1)} !== 16'h0300) begin
      errors++;
      $display("FAIL read_bytes: got %h want 0300", {mb(mb0), mb(mb0+1)});
    end
    checks++;
    if (cur_addr !== 16'h1236 || rdy_cyc !== 237) begin
      errors++;
      $display("FAIL read_cur: got %h rdy %0d want 1236 237",
               cur_addr, rdy_cyc);
    end
    issue(2'b10, 16'h0000, 8'h11);
    wait_done(600);
    checks++;
    if (rsp_data !== 8'h3C) begin
      errors++;
      $display("FAIL read_hold: got %h want 3c", rsp_data);
    end
  endtask

  task automatic test_wrap;
    rd_byte = 8'h96;
    issue(2'b01, 16'hFFFF, 8'h00);
    wait_done(600);
    checks++;
    if (cur_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_addr: got %h want ffff", cur_addr);
    end
    issue(2'b11, 16'h0000, 8'h00);
    wait_done(600);
    checks++;
    if (cur_addr !== 16'h0000 || rsp_data !== 8'h96) begin
      errors++;
      $display("FAIL wrap_read: got %h/%h want 0000/96", cur_addr, rsp_data);
    end
  endtask

  task automatic test_reset_mid;
    issue(2'b10, 16'h0000, 8'h5A);
    for (int c = 1; c < 50; c++) @(negedge clock_50);
    reset = 1'b1;
    @(posedge clock_50);
    #1 reset = 1'b0;
    @(negedge clock_50);
    checks++;
    if ({ss, sclk, cmd_ready, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL rstmid_pins: got %b want 1010",
               {ss, sclk, cmd_ready, busy});
    end
    checks++;
    if (cur_addr !== 16'h0000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_regs: got %h/%b want 0000/0",
               cur_addr, rsp_valid);
    end
    issue(2'b01, 16'h0010, 8'h00);
    wait_done(600);
    checks++;
    if (cur_addr !== 16'h0010 || rdy_cyc !== 365) begin
      errors++;
      $display("FAIL rstmid_addr: got %h rdy %0d want 0010 365",
               cur_addr, rdy_cyc);
    end
    checks++;
    if ({mb(mb0), mb(mb0+1), mb(mb0+2)} !== 24'h010010) begin
      errors++;
      $display("FAIL rstmid_bytes: got %h want 010010",
               {mb(mb0), mb(mb0+1), mb(mb0+2)});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a0;
    rd_byte = 8'hC3;
    @(negedge clock_50);
    a0    = cur_addr;
    mb0   = mbytes.size();
    sf0   = ss_falls;
    mbad0 = mosi_bad;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_wdata = 8'hFF;
    @(posedge clock_50);
    #1 cmd_op = 2'b11;
    @(negedge clock_50);
    checks++;
    if (cmd_ready !== 1'b1 || ss !== 1'b1 || cur_addr !== a0) begin
      errors++;
      $display("FAIL b2b_nop: rdy %b ss %b addr %h want 1 1 %h",
               cmd_ready, ss, cur_addr, a0);
    end
    @(posedge clock_50);
    #1 cmd_valid = 1'b0;
    cmd_op    = 2'b10;
    cmd_wdata = 8'hFF;
    wait_done(600);
    checks++;
    if (rdy_cyc !== 237 || rv_cyc !== 233 || rsp_data !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_read: rdy %0d rv %0d data %h want 237 233 c3",
               rdy_cyc, rv_cyc, rsp_data);
    end
    checks++;
    if ({mb(mb0), mb(mb0+1)} !== 16'h0300 || ss_falls - sf0 !== 1) begin
      errors++;
      $display("FAIL b2b_bytes: got %h falls %0d want 0300 1",
               {mb(mb0), mb(mb0+1)}, ss_falls - sf0);
    end
    checks++;
    if (cur_addr !== a0 + 16'd1 || mosi_bad - mbad0 !== 0) begin
      errors++;
      $display("FAIL b2b_cur: got %h bad %0d want %h 0",
               cur_addr, mosi_bad - mbad0, a0 + 16'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 16'h0000;
    cmd_wdata = 8'h00;
    test_reset;
    test_addr;
    test_write;
    test_read;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
